// File: rtl/cpu_clk_ctrl_if.sv
// Board-side control/status bundle for the CPU clock/run-control generator.
//   Hz         rate select (master -> slave)
//   mode       00 run, 01 halt, 10 single-step, 11 halt (master -> slave)
//   step       raw step pushbutton level, asynchronous (master -> slave)
//   clk_N      generated CPU clock (slave -> master)
//   rise_pulse one-clk pulse in the cycle clk_N goes 0->1 (slave -> master)
//   cycle_cnt  clk_N rising edges since reset, wraps (slave -> master)
//   state      0 IDLE, 1 RUN, 2 STEP, 3 DRAIN (slave -> master)
interface cpu_clk_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [1:0]       Hz;
  logic [1:0]       mode;
  logic             step;
  logic             clk_N;
  logic             rise_pulse;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       state;

  modport master (
    output Hz, mode, step,
    input  clk_N, rise_pulse, cycle_cnt, state
  );

  modport slave (
    input  Hz, mode, step,
    output clk_N, rise_pulse, cycle_cnt, state
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock / run-control generator. Derives clk_N from the board clock with
// four selectable half-periods (DIV0..DIV3, 0 treated as 1) and supports run,
// halt and single-step. Rate changes and stops only take effect at clean
// level boundaries, so clk_N never carries a runt pulse.
// Ports:
//   clk  board clock, all logic on its rising edge
//   clr  synchronous active-high reset
//   bus  cpu_clk_ctrl_if slave: Hz/mode/step in; clk_N, rise_pulse,
//        cycle_cnt, state out
module cpu_clk_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV0  = 10000,
  parameter int unsigned DIV1  = 100000,
  parameter int unsigned DIV2  = 1000000,
  parameter int unsigned DIV3  = 10000000
) (
  input  logic           clk,
  input  logic           clr,
  cpu_clk_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             clk_n_q, clk_n_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       sync_q, sync_d;

  logic             step_evt;
  logic             toggle;
  logic             clk_post;

  function automatic logic [CNT_W-1:0] div_sel(input logic [1:0] hz);
    logic [CNT_W-1:0] d;
    case (hz)
      2'd0:    d = CNT_W'(DIV0);
      2'd1:    d = CNT_W'(DIV1);
      2'd2:    d = CNT_W'(DIV2);
      default: d = CNT_W'(DIV3);
    endcase
    if (d == '0) d = CNT_W'(1);
    return d;
  endfunction

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect delay.
  assign step_evt = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      clk_n_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
      hcnt_q  <= CNT_W'(1);
      div_q   <= div_sel(bus.Hz);
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      clk_n_q <= clk_n_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      div_q   <= div_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clk_n_d  = clk_n_q;
    hcnt_d   = hcnt_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sync_d   = {sync_q[1:0], bus.step};
    toggle   = 1'b0;
    clk_post = clk_n_q;

    // The half-period counter runs in every state but IDLE. The toggle is
    // resolved first so that stop decisions below see the post-toggle level.
    if (state_q != IDLE) begin
      toggle   = (hcnt_q == div_q);
      clk_post = clk_n_q ^ toggle;
      clk_n_d  = clk_post;
      hcnt_d   = toggle ? CNT_W'(1) : hcnt_q + CNT_W'(1);
      // New rate is only picked up at the falling edge: a period never
      // changes length half way through.
      if (toggle && clk_n_q) div_d = div_sel(bus.Hz);
    end

    case (state_q)
      IDLE: begin
        if (bus.mode == 2'b00) begin
          state_d = RUN;
          hcnt_d  = CNT_W'(1);
          div_d   = div_sel(bus.Hz);
        end else if (bus.mode == 2'b10 && step_evt) begin
          state_d = STEP;
          clk_n_d = 1'b1;
          hcnt_d  = CNT_W'(1);
          div_d   = div_sel(bus.Hz);
        end
      end
      RUN: begin
        // Stopping with clk_N low is immediate; a high level is drained.
        if (bus.mode != 2'b00) state_d = clk_post ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.mode == 2'b00) state_d = RUN;
        else if (toggle)       state_d = IDLE;
      end
      STEP: begin
        if (toggle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rise_d = ~clk_n_q & clk_n_d;
    if (rise_d) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    bus.clk_N      = clk_n_q;
    bus.rise_pulse = rise_q;
    bus.cycle_cnt  = cnt_q;
    bus.state      = state_q;
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

  logic clk;
  logic clr;
  logic clr0;

  cpu_clk_ctrl_if #(.CNT_W(8)) bus  ();
  cpu_clk_ctrl_if #(.CNT_W(8)) bus0 ();

  cpu_clk_ctrl #(
    .CNT_W(8), .DIV0(2), .DIV1(3), .DIV2(4), .DIV3(5)
  ) u_dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  cpu_clk_ctrl #(
    .CNT_W(8), .DIV0(0), .DIV1(3), .DIV2(4), .DIV3(5)
  ) u_dut0 (
    .clk(clk), .clr(clr0), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit       cur_clr;
  bit [1:0] cur_hz;
  bit [1:0] cur_mode;
  bit       cur_step;

  // Reference model: states as plain ints, each clk_N level tracked as a
  // countdown of remaining board cycles.
  int       m_st;
  bit       m_clk;
  bit       m_rise;
  int       m_cnt;
  int       m_D;
  int       m_left;
  bit [2:0] m_hist;

  function automatic int dsel(input bit [1:0] h);
    int d;
    case (h)
      2'd0:    d = 2;
      2'd1:    d = 3;
      2'd2:    d = 4;
      default: d = 5;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit evt, prev, tog;
    if (cur_clr) begin
      m_st = 0; m_clk = 0; m_rise = 0; m_cnt = 0;
      m_D = dsel(cur_hz); m_left = m_D; m_hist = '0;
    end else begin
      // Step accepted when sampled high two edges ago and low three edges ago.
      evt    = m_hist[1] && !m_hist[2];
      m_hist = {m_hist[1:0], cur_step};
      prev   = m_clk;
      tog    = 0;
      if (m_st != 0) begin
        m_left--;
        if (m_left == 0) begin
          tog   = 1;
          m_clk = !m_clk;
          if (!m_clk) m_D = dsel(cur_hz);
          m_left = m_D;
        end
      end
      case (m_st)
        0: begin
          if (cur_mode == 2'b00) begin
            m_st = 1; m_D = dsel(cur_hz); m_left = m_D;
          end else if (cur_mode == 2'b10 && evt) begin
            m_st = 2; m_clk = 1; m_D = dsel(cur_hz); m_left = m_D;
          end
        end
        1: if (cur_mode != 2'b00) m_st = m_clk ? 3 : 0;
        3: begin
          if (cur_mode == 2'b00) m_st = 1;
          else if (tog)          m_st = 0;
        end
        default: if (tog) m_st = 0;
      endcase
      m_rise = !prev && m_clk;
      if (m_rise) m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic tick();
    logic [11:0] act, exp;
    clr      = cur_clr;
    bus.Hz   = cur_hz;
    bus.mode = cur_mode;
    bus.step = cur_step;
    @(posedge clk);
    model_edge();
    #1;
    act = {bus.clk_N, bus.rise_pulse, bus.cycle_cnt, bus.state};
    exp = {m_clk, m_rise, m_cnt[7:0], m_st[1:0]};
    check("model", 32'(act), 32'(exp));
  endtask

  task automatic wait_level(input logic v, input string name);
    int n = 0;
    while (bus.clk_N !== v && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(bus.clk_N), 32'(v));
  endtask

  task automatic measure(output int len);
    logic v;
    v   = bus.clk_N;
    len = 0;
    while (bus.clk_N === v && len < 100) begin
      tick();
      len++;
    end
  endtask

  typedef struct packed {
    logic       clr;
    logic [1:0] hz;
    logic [1:0] mode;
    logic       step;
    logic       clk_n;
    logic       rise;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int len, c0, n;

    tbl[0]  = '{1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    tbl[1]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd1};
    tbl[2]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd1};
    tbl[3]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1};
    tbl[4]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1};
    tbl[5]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1};
    tbl[6]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1};
    tbl[7]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd2, 2'd1};
    tbl[8]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd2, 2'd1};
    tbl[9]  = '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2, 2'd0};
    tbl[10] = '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd2, 2'd0};

    clr0      = 1'b1;
    bus0.Hz   = 2'd0;
    bus0.mode = 2'd0;
    bus0.step = 1'b0;

    // Reset and run at rate 0, then halt on a falling toggle.
    for (int i = 0; i < 11; i++) begin
      cur_clr  = tbl[i].clr;
      cur_hz   = tbl[i].hz;
      cur_mode = tbl[i].mode;
      cur_step = tbl[i].step;
      tick();
      check($sformatf("tbl%0d", i),
            32'({bus.clk_N, bus.rise_pulse, bus.cycle_cnt, bus.state}),
            32'({tbl[i].clk_n, tbl[i].rise, tbl[i].cnt, tbl[i].st}));
    end

    // Rate change while clk_N is high: current level keeps its length.
    cur_mode = 2'b00; cur_hz = 2'd0;
    wait_level(1'b1, "rate_rise");
    cur_hz = 2'd3;
    measure(len); check("rate_hi_old", 32'(len), 32'd2);
    measure(len); check("rate_lo_new", 32'(len), 32'd5);
    measure(len); check("rate_hi_new", 32'(len), 32'd5);

    // Halt one cycle into a 4-cycle high level: drain, then IDLE.
    cur_hz = 2'd2;
    wait_level(1'b1, "halt_w1");
    wait_level(1'b0, "halt_w2");
    wait_level(1'b1, "halt_w3");
    cur_mode = 2'b01;
    tick();
    check("halt_drain", 32'({bus.clk_N, bus.state}), 32'({1'b1, 2'd3}));
    measure(len); check("halt_hi_rest", 32'(len), 32'd3);
    check("halt_idle", 32'(bus.state), 32'd0);
    c0 = int'(bus.cycle_cnt);
    repeat (6) tick();
    check("halt_frozen", 32'(bus.cycle_cnt), 32'(c0));

    // Single step at Hz=01: two long presses, then a press inside STEP.
    cur_mode = 2'b10; cur_hz = 2'd1;
    c0 = int'(bus.cycle_cnt);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        cur_step = 1'b1;
        tick();
        if (i == 1) check("step_wait", 32'(bus.clk_N), 32'd0);
        if (i == 2) check("step_rise", 32'({bus.clk_N, bus.rise_pulse, bus.state}),
                          32'({1'b1, 1'b1, 2'd2}));
        if (i == 5) check("step_fall", 32'({bus.clk_N, bus.state}), 32'({1'b0, 2'd0}));
      end
      cur_step = 1'b0;
      repeat (5) tick();
      check("step_cnt", 32'(bus.cycle_cnt), 32'((c0 + p + 1) % 256));
    end
    cur_step = 1'b1; tick();
    cur_step = 1'b0; tick();
    cur_step = 1'b1; tick();
    cur_step = 1'b0; tick();
    repeat (6) tick();
    check("step_ignored", 32'(bus.cycle_cnt), 32'((c0 + 3) % 256));

    // Counter wrap, then reset while clk_N is high.
    cur_mode = 2'b00; cur_hz = 2'd0;
    n = 0;
    while (bus.cycle_cnt !== 8'd255 && n < 3000) begin
      tick();
      n++;
    end
    check("wrap_pre", 32'(bus.cycle_cnt), 32'd255);
    wait_level(1'b0, "wrap_w0");
    wait_level(1'b1, "wrap_w1");
    check("wrap_zero", 32'({bus.rise_pulse, bus.cycle_cnt}), 32'({1'b1, 8'd0}));
    cur_clr = 1'b1;
    tick();
    check("clr_high", 32'({bus.clk_N, bus.rise_pulse, bus.cycle_cnt, bus.state}), 32'd0);
    cur_clr = 1'b0;

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) cur_clr = 1'b1;
      else                          cur_clr = 1'b0;
      if ($urandom_range(19) == 0)  cur_hz   = 2'($urandom_range(3));
      if ($urandom_range(14) == 0)  cur_mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0)   cur_step = ~cur_step;
      tick();
    end
    cur_clr = 1'b0;

    // Zero divisor: clk_N toggles every board clock.
    clr0 = 1'b0;
    tick();
    check("zdiv_entry", 32'({bus0.clk_N, bus0.state}), 32'({1'b0, 2'd1}));
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("zdiv_%0d", k), 32'({bus0.clk_N, bus0.rise_pulse}),
            32'({k[0], k[0]}));
    end
    check("zdiv_cnt", 32'(bus0.cycle_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
